control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Control unit of the 8-bit accumulator-pair CPU (registers A, B, PC, IR, ZF).
- Takes the current FSM state from the external state register and the IR contents.
- Produces the next state plus every datapath enable/select for that cycle, decoded combinationally.
- Holds one internal sticky halted flag.
- Sits between the IR/state register and the datapath muxes/write enables.

Parameters:
None. State and opcode encodings are fixed constants from the shared package.

Ports:
clk  in  1  system clock; only the halted flag is clocked
reset  in  1  asynchronous, active-high
instr  in  8  IR contents: [7:5] opcode, [4] register select r (0=A, 1=B), [3:2] ALU operand selects, [3:0] imm4
state  in  3  current FSM state
zf  in  1  zero flag
next_state  out  3  state for next cycle
pc_we  out  1  PC write enable
pc_sel  out  1  PC source: 0=PC+1, 1=jump target
pc_jmp_sel  out  1  jump base register: 0=A, 1=B; target = base + imm4
pc_offset  out  4  jump offset
addr_sel  out  1  memory address: 0=PC, 1=A+addr_offset
addr_offset  out  4  data address offset
mem_sel  out  1  store data source: 0=A, 1=B
mem_we  out  1  memory write enable
alu_opcode  out  3  000 ADD, 001 AND, 010 NOT (of operand a)
alu_sel_a  out  1  ALU operand a: 0=A, 1=B
alu_sel_b  out  1  ALU operand b: 0=A, 1=B
alu_we  out  1  ALU result register write enable
zf_we  out  1  zero flag write enable
ir_we  out  1  IR write enable
a_sel  out  1  A write source: 0=ALU result, 1=memory read data
a_we  out  1  A write enable
b_sel  out  1  B write source: 0=ALU result, 1=memory read data
b_we  out  1  B write enable
halt  out  1  processor halted

Behaviour:
- States: FETCH=000, DECODE=001, EXECUTE=010, MEMORY=011, WRITEBACK=100, HALT_STATE=101. Codes 110/111 are illegal.
- Opcodes: 000 ADD, 001 AND, 010 NOT, 011 LOAD, 100 STORE, 101 JUMP, 110 JUMPZ, 111 HALT.
- All outputs are combinational from state/instr/zf/reset/halted_q, with zero-latency response. Any output not listed for a state is 0.
- reset=1 (asynchronous): every output is 0, next_state=FETCH, halted_q cleared immediately.
- FETCH: ir_we=1, addr_sel=0, pc_we=1, pc_sel=0; next_state=DECODE.
- DECODE: no enables.
  - next_state=EXECUTE for ADD/AND/NOT/JUMP/JUMPZ.
  - MEMORY for LOAD/STORE.
  - HALT_STATE for HALT.
- EXECUTE:
  - ADD/AND/NOT: alu_opcode=instr[7:5], alu_sel_a=instr[3], alu_sel_b=instr[2], alu_we=1, zf_we=1; next_state=WRITEBACK.
  - JUMP: pc_we=1, pc_sel=1, pc_jmp_sel=instr[4], pc_offset=instr[3:0]; next_state=FETCH.
  - JUMPZ with zf=1: same as JUMP. With zf=0: all PC outputs 0 (pc_offset=0); next_state=FETCH.
  - Other opcodes: no enables; next_state=FETCH.
- In all non-ALU contexts alu_opcode/alu_sel_a/alu_sel_b are 0. pc_offset and pc_jmp_sel are 0 unless a jump is taken.
- MEMORY: addr_sel=1, addr_offset=instr[3:0].
  - STORE: mem_we=1, mem_sel=instr[4]; next_state=FETCH.
  - LOAD: next_state=WRITEBACK.
  - Other opcodes: next_state=FETCH.
- WRITEBACK: write enable for register r = instr[4] (a_we if 0, b_we if 1); the other register's enable is 0.
  - ALU ops: chosen *_sel=0.
  - LOAD: chosen *_sel=1, with addr_sel=1 and addr_offset=instr[3:0] held.
  - Other opcodes: no enables.
  - next_state=FETCH.
- HALT_STATE: halt=1; next_state=HALT_STATE.
- halted_q:
  - Set on rising clk when state==HALT_STATE.
  - While set: halt=1, next_state=HALT_STATE, all other outputs 0, regardless of state input.
  - Cleared only by reset.
- Illegal states 110/111: all outputs 0; next_state=FETCH.

Decomposition:
- Shared package cpu_pkg: state encodings, opcode encodings, ALU opcode constants, instr field bit positions.
- One natural sub-module, control_decode: combinational opcode/field decode into is_alu/is_load/is_store/is_jump/is_jumpz/is_halt, r, imm4.

Test Plan:
- reset=1, state=EXECUTE, instr=0x14 -> every output 0, next_state=FETCH. Release reset, same inputs -> next_state=WRITEBACK, alu_opcode=000, sel_a=0, sel_b=1, alu_we=zf_we=1.
- EXECUTE with instr 0x28 (AND A,B,A) -> alu_opcode=001, sel_a=1, sel_b=0. Instr 0x50 (NOT B,A) -> alu_opcode=010, sel_a=0, sel_b=0. Both: next_state=WRITEBACK, no PC/memory/register enables.
- EXECUTE: 0xAF -> pc_we=pc_sel=1, pc_jmp_sel=0, pc_offset=1111, next_state=FETCH. 0xB5 -> pc_jmp_sel=1, pc_offset=0101.
- EXECUTE 0xD3: zf=0 -> all PC outputs 0, next_state=FETCH. zf=1 -> pc_we=pc_sel=pc_jmp_sel=1, pc_offset=0011.
- Full LOAD 0x73 cycle:
  - FETCH -> ir_we=pc_we=1, next_state=DECODE.
  - DECODE -> next_state=MEMORY.
  - MEMORY -> addr_sel=1, addr_offset=0011, next_state=WRITEBACK.
  - WRITEBACK -> b_we=b_sel=1, next_state=FETCH.
  - Also STORE 0x82 in MEMORY -> mem_we=1, mem_sel=0, addr_offset=0010, next_state=FETCH.
- DECODE with 0xE0 -> next_state=HALT_STATE. HALT_STATE + clk edge -> halt=1. Then drive state=FETCH -> halt stays 1, next_state=HALT_STATE. Assert reset between clock edges -> halt=0 immediately. State=110 -> outputs 0, next_state=FETCH.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit accumulator-pair CPU.
// Covers FSM states, instruction opcodes, ALU function codes and instruction field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH      = 3'b000,
        DECODE     = 3'b001,
        EXECUTE    = 3'b010,
        MEMORY     = 3'b011,
        WRITEBACK  = 3'b100,
        HALT_STATE = 3'b101
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_NOT   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_JUMP  = 3'b101;
    localparam logic [2:0] OP_JUMPZ = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;

    localparam int OPC_MSB   = 7;
    localparam int OPC_LSB   = 5;
    localparam int R_BIT     = 4;
    localparam int SEL_A_BIT = 3;
    localparam int SEL_B_BIT = 2;
    localparam int IMM_MSB   = 3;

    // ALU-class opcodes share their encoding with the ALU function code
    function automatic logic is_alu_op(input logic [2:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decode: opcode class flags plus the register-select,
// ALU operand-select and imm4 fields.
module control_decode
    import cpu_pkg::*;
(
    input  logic [7:0] instr,
    output logic [2:0] opcode,
    output logic       is_alu,
    output logic       is_load,
    output logic       is_store,
    output logic       is_jump,
    output logic       is_jumpz,
    output logic       is_halt,
    output logic       r,
    output logic       sel_a,
    output logic       sel_b,
    output logic [3:0] imm4
);

    assign opcode = instr[OPC_MSB:OPC_LSB];
    assign r      = instr[R_BIT];
    assign sel_a  = instr[SEL_A_BIT];
    assign sel_b  = instr[SEL_B_BIT];
    assign imm4   = instr[IMM_MSB:0];
    assign is_alu = is_alu_op(opcode);

    // Opcode class flags for the non-ALU instructions
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_jump  = 1'b0;
        is_jumpz = 1'b0;
        is_halt  = 1'b0;
        case (opcode)
            OP_LOAD:  is_load  = 1'b1;
            OP_STORE: is_store = 1'b1;
            OP_JUMP:  is_jump  = 1'b1;
            OP_JUMPZ: is_jumpz = 1'b1;
            OP_HALT:  is_halt  = 1'b1;
            default:  is_load  = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Control unit for the accumulator-pair CPU: decodes state and IR into next state
// and datapath controls; a sticky halted flag is the only clocked element.
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic [2:0] state,
    input  logic       zf,
    output logic [2:0] next_state,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       pc_jmp_sel,
    output logic [3:0] pc_offset,
    output logic       addr_sel,
    output logic [3:0] addr_offset,
    output logic       mem_sel,
    output logic       mem_we,
    output logic [2:0] alu_opcode,
    output logic       alu_sel_a,
    output logic       alu_sel_b,
    output logic       alu_we,
    output logic       zf_we,
    output logic       ir_we,
    output logic       a_sel,
    output logic       a_we,
    output logic       b_sel,
    output logic       b_we,
    output logic       halt
);

    logic [2:0] opcode_s;
    logic       is_alu_s;
    logic       is_load_s;
    logic       is_store_s;
    logic       is_jump_s;
    logic       is_jumpz_s;
    logic       is_halt_s;
    logic       r_s;
    logic       sel_a_s;
    logic       sel_b_s;
    logic [3:0] imm4_s;
    logic       jump_taken_s;
    logic       halted_r;

    control_decode u_decode (
        .instr    (instr),
        .opcode   (opcode_s),
        .is_alu   (is_alu_s),
        .is_load  (is_load_s),
        .is_store (is_store_s),
        .is_jump  (is_jump_s),
        .is_jumpz (is_jumpz_s),
        .is_halt  (is_halt_s),
        .r        (r_s),
        .sel_a    (sel_a_s),
        .sel_b    (sel_b_s),
        .imm4     (imm4_s)
    );

    assign jump_taken_s = is_jump_s || (is_jumpz_s && zf);

    // Sticky halted flag, set on any clock edge seen in HALT_STATE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_r <= 1'b0;
        end else if (state == HALT_STATE) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        next_state  = FETCH;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        pc_jmp_sel  = 1'b0;
        pc_offset   = 4'b0000;
        addr_sel    = 1'b0;
        addr_offset = 4'b0000;
        mem_sel     = 1'b0;
        mem_we      = 1'b0;
        alu_opcode  = 3'b000;
        alu_sel_a   = 1'b0;
        alu_sel_b   = 1'b0;
        alu_we      = 1'b0;
        zf_we       = 1'b0;
        ir_we       = 1'b0;
        a_sel       = 1'b0;
        a_we        = 1'b0;
        b_sel       = 1'b0;
        b_we        = 1'b0;
        halt        = 1'b0;
        if (reset) begin
            next_state = FETCH;
        end else if (halted_r) begin
            halt       = 1'b1;
            next_state = HALT_STATE;
        end else begin
            case (state)
                FETCH: begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    next_state = DECODE;
                end
                DECODE: begin
                    if (is_load_s || is_store_s) begin
                        next_state = MEMORY;
                    end else if (is_halt_s) begin
                        next_state = HALT_STATE;
                    end else begin
                        next_state = EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (is_alu_s) begin
                        alu_opcode = opcode_s;
                        alu_sel_a  = sel_a_s;
                        alu_sel_b  = sel_b_s;
                        alu_we     = 1'b1;
                        zf_we      = 1'b1;
                        next_state = WRITEBACK;
                    end else if (jump_taken_s) begin
                        pc_we      = 1'b1;
                        pc_sel     = 1'b1;
                        pc_jmp_sel = r_s;
                        pc_offset  = imm4_s;
                        next_state = FETCH;
                    end else begin
                        next_state = FETCH;
                    end
                end
                MEMORY: begin
                    addr_sel    = 1'b1;
                    addr_offset = imm4_s;
                    if (is_store_s) begin
                        mem_we     = 1'b1;
                        mem_sel    = r_s;
                        next_state = FETCH;
                    end else if (is_load_s) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = FETCH;
                    end
                end
                WRITEBACK: begin
                    // r chooses the destination; loads take memory data and keep the address
                    if (is_alu_s || is_load_s) begin
                        a_we  = ~r_s;
                        b_we  = r_s;
                        a_sel = is_load_s & ~r_s;
                        b_sel = is_load_s & r_s;
                    end else begin
                        a_we = 1'b0;
                    end
                    if (is_load_s) begin
                        addr_sel    = 1'b1;
                        addr_offset = imm4_s;
                    end else begin
                        addr_sel = 1'b0;
                    end
                    next_state = FETCH;
                end
                HALT_STATE: begin
                    halt       = 1'b1;
                    next_state = HALT_STATE;
                end
                default: begin
                    next_state = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed walk through the key cases, then
// randomized inputs compared against a behavioural model of the control rules.
module tb_control_unit;

    typedef struct packed {
        logic [2:0] next_state;
        logic       pc_we;
        logic       pc_sel;
        logic       pc_jmp_sel;
        logic [3:0] pc_offset;
        logic       addr_sel;
        logic [3:0] addr_offset;
        logic       mem_sel;
        logic       mem_we;
        logic [2:0] alu_opcode;
        logic       alu_sel_a;
        logic       alu_sel_b;
        logic       alu_we;
        logic       zf_we;
        logic       ir_we;
        logic       a_sel;
        logic       a_we;
        logic       b_sel;
        logic       b_we;
        logic       halt;
    } outs_t;

    logic       clk;
    logic       reset;
    logic [7:0] instr;
    logic [2:0] state;
    logic       zf;
    logic [2:0] next_state;
    logic       pc_we, pc_sel, pc_jmp_sel;
    logic [3:0] pc_offset;
    logic       addr_sel;
    logic [3:0] addr_offset;
    logic       mem_sel, mem_we;
    logic [2:0] alu_opcode;
    logic       alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we;
    logic       a_sel, a_we, b_sel, b_we, halt;

    int  checks = 0;
    int  errors = 0;
    logic m_halted;

    control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .state       (state),
        .zf          (zf),
        .next_state  (next_state),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .pc_jmp_sel  (pc_jmp_sel),
        .pc_offset   (pc_offset),
        .addr_sel    (addr_sel),
        .addr_offset (addr_offset),
        .mem_sel     (mem_sel),
        .mem_we      (mem_we),
        .alu_opcode  (alu_opcode),
        .alu_sel_a   (alu_sel_a),
        .alu_sel_b   (alu_sel_b),
        .alu_we      (alu_we),
        .zf_we       (zf_we),
        .ir_we       (ir_we),
        .a_sel       (a_sel),
        .a_we        (a_we),
        .b_sel       (b_sel),
        .b_we        (b_we),
        .halt        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference halted flag: any clock edge in state 5 latches it until reset
    always @(posedge clk or posedge reset) begin
        if (reset) m_halted <= 1'b0;
        else if (state == 3'd5) m_halted <= 1'b1;
        else m_halted <= m_halted;
    end

    function automatic outs_t model(input logic rst, input logic hlt, input int st,
                                    input logic [7:0] ins, input logic z);
        outs_t o;
        int op;
        int r;
        int imm;
        o   = '0;
        op  = int'(ins) / 32;
        r   = (int'(ins) / 16) % 2;
        imm = int'(ins) % 16;
        if (rst) return o;
        if (hlt) begin
            o.halt = 1'b1;
            o.next_state = 3'd5;
            return o;
        end
        if (st == 0) begin
            o.ir_we = 1'b1;
            o.pc_we = 1'b1;
            o.next_state = 3'd1;
        end else if (st == 1) begin
            if (op == 3 || op == 4) o.next_state = 3'd3;
            else if (op == 7) o.next_state = 3'd5;
            else o.next_state = 3'd2;
        end else if (st == 2) begin
            if (op <= 2) begin
                o.alu_opcode = 3'(op);
                o.alu_sel_a  = ins[3];
                o.alu_sel_b  = ins[2];
                o.alu_we     = 1'b1;
                o.zf_we      = 1'b1;
                o.next_state = 3'd4;
            end else if (op == 5 || (op == 6 && z)) begin
                o.pc_we      = 1'b1;
                o.pc_sel     = 1'b1;
                o.pc_jmp_sel = (r == 1);
                o.pc_offset  = 4'(imm);
            end
        end else if (st == 3) begin
            o.addr_sel    = 1'b1;
            o.addr_offset = 4'(imm);
            if (op == 4) begin
                o.mem_we  = 1'b1;
                o.mem_sel = (r == 1);
            end
            if (op == 3) o.next_state = 3'd4;
        end else if (st == 4) begin
            if (op <= 3) begin
                if (r == 1) o.b_we = 1'b1;
                else o.a_we = 1'b1;
            end
            if (op == 3) begin
                if (r == 1) o.b_sel = 1'b1;
                else o.a_sel = 1'b1;
                o.addr_sel    = 1'b1;
                o.addr_offset = 4'(imm);
            end
        end else if (st == 5) begin
            o.halt = 1'b1;
            o.next_state = 3'd5;
        end
        return o;
    endfunction

    task automatic check(input string tag);
        outs_t got;
        outs_t exp;
        got.next_state  = next_state;
        got.pc_we       = pc_we;
        got.pc_sel      = pc_sel;
        got.pc_jmp_sel  = pc_jmp_sel;
        got.pc_offset   = pc_offset;
        got.addr_sel    = addr_sel;
        got.addr_offset = addr_offset;
        got.mem_sel     = mem_sel;
        got.mem_we      = mem_we;
        got.alu_opcode  = alu_opcode;
        got.alu_sel_a   = alu_sel_a;
        got.alu_sel_b   = alu_sel_b;
        got.alu_we      = alu_we;
        got.zf_we       = zf_we;
        got.ir_we       = ir_we;
        got.a_sel       = a_sel;
        got.a_we        = a_we;
        got.b_sel       = b_sel;
        got.b_we        = b_we;
        got.halt        = halt;
        exp = model(reset, m_halted, int'(state), instr, zf);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s state=%0d instr=%h zf=%0d rst=%0d observed=%h expected=%h",
                   tag, state, instr, zf, reset, got, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic [2:0] st, input logic [7:0] ins,
                         input logic z, input string tag);
        @(negedge clk);
        reset = rst;
        state = st;
        instr = ins;
        zf    = z;
        #1;
        check(tag);
    endtask

    initial begin
        logic [2:0] st;
        reset = 1'b1;
        state = 3'd2;
        instr = 8'h14;
        zf    = 1'b0;

        apply(1'b1, 3'd2, 8'h14, 1'b0, "reset_all_zero");
        apply(1'b0, 3'd2, 8'h14, 1'b0, "exec_add");
        apply(1'b0, 3'd2, 8'h28, 1'b0, "exec_and");
        apply(1'b0, 3'd2, 8'h50, 1'b0, "exec_not");
        apply(1'b0, 3'd2, 8'hAF, 1'b0, "exec_jump_a");
        apply(1'b0, 3'd2, 8'hB5, 1'b0, "exec_jump_b");
        apply(1'b0, 3'd2, 8'hD3, 1'b0, "exec_jumpz_nt");
        apply(1'b0, 3'd2, 8'hD3, 1'b1, "exec_jumpz_t");
        apply(1'b0, 3'd0, 8'h73, 1'b0, "load_fetch");
        apply(1'b0, 3'd1, 8'h73, 1'b0, "load_decode");
        apply(1'b0, 3'd3, 8'h73, 1'b0, "load_memory");
        apply(1'b0, 3'd4, 8'h73, 1'b0, "load_writeback");
        apply(1'b0, 3'd3, 8'h82, 1'b0, "store_memory");
        apply(1'b0, 3'd4, 8'h14, 1'b0, "alu_writeback_a");
        apply(1'b0, 3'd1, 8'hE0, 1'b0, "halt_decode");
        apply(1'b0, 3'd5, 8'hE0, 1'b0, "halt_state");
        apply(1'b0, 3'd0, 8'h14, 1'b0, "halted_sticky");
        apply(1'b0, 3'd2, 8'hAF, 1'b1, "halted_sticky_exec");
        apply(1'b1, 3'd0, 8'h14, 1'b0, "reset_clears_halt");
        apply(1'b0, 3'd6, 8'h14, 1'b0, "illegal_110");
        apply(1'b0, 3'd7, 8'hAF, 1'b1, "illegal_111");

        for (int i = 0; i < 400; i++) begin
            st = 3'($urandom_range(0, 7));
            if (st == 3'd5 && $urandom_range(0, 3) != 0) st = 3'd2;
            apply(($urandom_range(0, 7) == 0), st, 8'($urandom), 1'($urandom), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
